// File: rtl/pmem_arbiter.sv
// Arbitrates NUM_PORTS cache ports onto one L2 command channel (IDLE/GRANT/TURN FSM).
// Latency: request seen at edge t drives the L2 command from t+1; resp no earlier than 2 cycles.
// Backpressure: level requests are held until req_resp; L2 stalls via l2_resp, optional sticky timeout.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_read/req_write/req_address/req_wdata   per-port requests (port i at [i*W +: W])
//   req_resp, req_rdata             one-hot completion pulse and shared read data
//   l2_read/l2_write/l2_address/l2_wdata/l2_rdata/l2_resp   L2 command channel
//   busy, grant_id, timeout_err     status
module pmem_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 128,
   parameter int RR_MODE    = 1,
   parameter int TURNAROUND = 1,
   parameter int TIMEOUT    = 1023
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          req_read,
   input  logic [NUM_PORTS-1:0]          req_write,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_address,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
   output logic [NUM_PORTS-1:0]          req_resp,
   output logic [DATA_W-1:0]             req_rdata,
   output logic                          l2_read,
   output logic                          l2_write,
   output logic [ADDR_W-1:0]             l2_address,
   output logic [DATA_W-1:0]             l2_wdata,
   input  logic [DATA_W-1:0]             l2_rdata,
   input  logic                          l2_resp,
   output logic                          busy,
   output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
   output logic                          timeout_err
);

   localparam int ID_W = $clog2(NUM_PORTS);
   localparam int TA_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
   localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TA_W-1:0] TA_LAST = TA_W'(TURNAROUND - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic                lat_rd, lat_wr;
   logic [TA_W-1:0]     turn_cnt;
   logic [TO_W-1:0]     to_cnt;

   logic [NUM_PORTS-1:0] act;
   logic                 any_req;
   logic [ID_W-1:0]      win_id;
   logic [ID_W-1:0]      scan_id;
   logic [ADDR_W-1:0]    win_addr;
   logic [DATA_W-1:0]    win_wdata;

   assign act = req_read | req_write;

   // Winner search: round-robin starts at rr_ptr and wraps, fixed priority starts at 0.
   always_comb begin
      any_req   = 1'b0;
      win_id    = '0;
      scan_id   = '0;
      win_addr  = '0;
      win_wdata = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         scan_id = (RR_MODE != 0) ? ID_W'((int'(rr_ptr) + k) % NUM_PORTS) : ID_W'(k);
         if (!any_req && act[scan_id]) begin
            any_req = 1'b1;
            win_id  = scan_id;
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (win_id == ID_W'(i)) begin
            win_addr  = req_address[i*ADDR_W +: ADDR_W];
            win_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (any_req) state_nxt = GRANT;
         GRANT: if (l2_resp) state_nxt = (TURNAROUND > 0) ? TURN : IDLE;
         TURN:  if (turn_cnt == TA_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latched command, pointers and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_id    <= '0;
         rr_ptr      <= '0;
         lat_rd      <= 1'b0;
         lat_wr      <= 1'b0;
         l2_address  <= '0;
         l2_wdata    <= '0;
         turn_cnt    <= '0;
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            grant_id   <= win_id;
            // A port asking for both is served as a write only.
            lat_wr     <= req_write[win_id];
            lat_rd     <= req_read[win_id] & ~req_write[win_id];
            l2_address <= win_addr;
            l2_wdata   <= win_wdata;
            to_cnt     <= '0;
            if (RR_MODE != 0)
               rr_ptr <= (win_id == ID_W'(NUM_PORTS - 1)) ? '0 : win_id + ID_W'(1);
         end
         if (state == TURN) turn_cnt <= turn_cnt + 1'b1;
         else               turn_cnt <= '0;
         // Timeout only flags the stall; the transaction keeps waiting for l2_resp.
         if (state == GRANT && !l2_resp && TIMEOUT != 0) begin
            if (to_cnt != TO_MAX)  to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) timeout_err <= 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      l2_read   = (state == GRANT) && lat_rd;
      l2_write  = (state == GRANT) && lat_wr;
      busy      = (state != IDLE);
      req_resp  = '0;
      req_rdata = '0;
      if (state == GRANT && l2_resp) begin
         req_resp[grant_id] = 1'b1;
         req_rdata          = l2_rdata;
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a round-robin instance (TURNAROUND=2, TIMEOUT=8) and a
// fixed-priority instance (TURNAROUND=0, no timeout), each with its own L2 responder
// and clients, checked every cycle against a transaction-level model.
module tb_pmem_arbiter;

   localparam int TA_C [2] = '{2, 0};
   localparam int RR_C [2] = '{1, 0};
   localparam int TO_C [2] = '{8, 0};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]   rrd [2];
   logic [3:0]   rwr [2];
   logic [63:0]  radr [2];
   logic [511:0] rwd [2];
   logic [3:0]   resp [2];
   logic [127:0] rdat [2];
   logic         l2r [2];
   logic         l2w [2];
   logic [15:0]  l2a [2];
   logic [127:0] l2wd [2];
   logic [127:0] l2rd [2];
   logic         l2rsp [2];
   logic         bsy [2];
   logic [1:0]   gid [2];
   logic         err [2];

   pmem_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(128), .RR_MODE(1),
                  .TURNAROUND(2), .TIMEOUT(8)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_read(rrd[0]), .req_write(rwr[0]),
      .req_address(radr[0]), .req_wdata(rwd[0]), .req_resp(resp[0]), .req_rdata(rdat[0]),
      .l2_read(l2r[0]), .l2_write(l2w[0]), .l2_address(l2a[0]), .l2_wdata(l2wd[0]),
      .l2_rdata(l2rd[0]), .l2_resp(l2rsp[0]), .busy(bsy[0]), .grant_id(gid[0]),
      .timeout_err(err[0]));

   pmem_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(128), .RR_MODE(0),
                  .TURNAROUND(0), .TIMEOUT(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req_read(rrd[1]), .req_write(rwr[1]),
      .req_address(radr[1]), .req_wdata(rwd[1]), .req_resp(resp[1]), .req_rdata(rdat[1]),
      .l2_read(l2r[1]), .l2_write(l2w[1]), .l2_address(l2a[1]), .l2_wdata(l2wd[1]),
      .l2_rdata(l2rd[1]), .l2_resp(l2rsp[1]), .busy(bsy[1]), .grant_id(gid[1]),
      .timeout_err(err[1]));

   int vectors = 0;
   int miscompares = 0;

   // Environment state
   int           rsp_lat [2];
   bit           stray [2];
   int           lcnt [2];
   int           keep [2][4];
   int           rcnt [2][4];
   logic [3:0]   last_resp [2];
   logic [127:0] last_rdata [2];
   int           glog [2][16];
   int           glen [2];
   int           cyc_rd [2];
   int           turn_cyc [2];

   // Model: who owns L2 (-1 = nobody), remaining turnaround, cycles waited.
   int           m_owner [2];
   bit           m_wr [2];
   logic [15:0]  m_addr [2];
   logic [127:0] m_wd [2];
   int           m_cool [2];
   int           m_wait [2];
   bit           m_err [2];
   int           m_ptr [2];
   int           m_gid [2];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset(input int d);
      m_owner[d] = -1; m_wr[d] = 1'b0; m_addr[d] = '0; m_wd[d] = '0;
      m_cool[d] = 0; m_wait[d] = 0; m_err[d] = 1'b0; m_ptr[d] = 0; m_gid[d] = 0;
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int w;
         int p;
         w = -1;
         if (!rst_n) model_reset(d);
         else if (m_owner[d] >= 0) begin
            if (l2rsp[d]) begin
               m_owner[d] = -1;
               m_cool[d]  = TA_C[d];
            end else begin
               m_wait[d]++;
               if (TO_C[d] != 0 && m_wait[d] >= TO_C[d]) m_err[d] = 1'b1;
            end
         end else if (m_cool[d] > 0) m_cool[d]--;
         else begin
            for (int k = 0; k < 4; k++) begin
               p = ((RR_C[d] != 0 ? m_ptr[d] : 0) + k) % 4;
               if (w < 0 && (rrd[d][p] || rwr[d][p])) w = p;
            end
            if (w >= 0) begin
               m_owner[d] = w;
               m_wr[d]    = rwr[d][w];
               m_addr[d]  = 16'(radr[d] >> (w * 16));
               m_wd[d]    = 128'(rwd[d] >> (w * 128));
               m_wait[d]  = 0;
               m_gid[d]   = w;
               if (RR_C[d] != 0) m_ptr[d] = (w + 1) % 4;
            end
         end
      end
   endtask

   task automatic compare();
      for (int d = 0; d < 2; d++) begin
         logic [3:0]   e_resp;
         logic [127:0] e_rdata;
         logic         e_r, e_w, e_busy, e_err;
         logic [1:0]   e_gid;
         int           own;
         own = rst_n ? m_owner[d] : -1;
         e_r     = (own >= 0) && !m_wr[d];
         e_w     = (own >= 0) && m_wr[d];
         e_resp  = (own >= 0 && l2rsp[d]) ? (4'b0001 << own) : 4'b0000;
         e_rdata = (e_resp != 4'b0000) ? l2rd[d] : '0;
         e_busy  = rst_n && ((own >= 0) || (m_cool[d] > 0));
         e_gid   = rst_n ? 2'(m_gid[d]) : 2'd0;
         e_err   = rst_n && m_err[d];
         chk($sformatf("d%0d req_resp", d), 128'(resp[d]), 128'(e_resp));
         chk($sformatf("d%0d req_rdata", d), rdat[d], e_rdata);
         chk($sformatf("d%0d l2_read", d), 128'(l2r[d]), 128'(e_r));
         chk($sformatf("d%0d l2_write", d), 128'(l2w[d]), 128'(e_w));
         chk($sformatf("d%0d busy", d), 128'(bsy[d]), 128'(e_busy));
         chk($sformatf("d%0d grant_id", d), 128'(gid[d]), 128'(e_gid));
         chk($sformatf("d%0d timeout_err", d), 128'(err[d]), 128'(e_err));
         if (own >= 0) begin
            chk($sformatf("d%0d l2_address", d), 128'(l2a[d]), 128'(m_addr[d]));
            chk($sformatf("d%0d l2_wdata", d), l2wd[d], m_wd[d]);
         end
         last_resp[d] = resp[d];
         if (resp[d] != 4'b0000) begin
            last_rdata[d] = rdat[d];
            for (int i = 0; i < 4; i++)
               if (resp[d][i] && glen[d] < 16) begin
                  glog[d][glen[d]] = i;
                  glen[d]++;
               end
         end
         cyc_rd[d]   += int'(l2r[d]);
         turn_cyc[d] += int'(bsy[d] && !l2r[d] && !l2w[d]);
      end
   endtask

   // L2 responder and clients, driven just after the active edge.
   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         l2rsp[d] = stray[d];
         if (l2r[d] || l2w[d]) begin
            lcnt[d]++;
            if (rsp_lat[d] != 0 && lcnt[d] >= rsp_lat[d]) begin
               l2rsp[d] = 1'b1;
               lcnt[d]  = 0;
            end
         end else lcnt[d] = 0;
         l2rd[d] = {8{l2a[d] ^ 16'hC3C3}};
         for (int i = 0; i < 4; i++)
            if (last_resp[d][i]) begin
               rcnt[d][i]++;
               if (rcnt[d][i] >= keep[d][i]) begin
                  rrd[d][i] = 1'b0;
                  rwr[d][i] = 1'b0;
               end
            end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         compare();
         @(posedge clk);
         model_step();
         #1;
         drive();
      end
   endtask

   task automatic clr_stats();
      for (int d = 0; d < 2; d++) begin
         glen[d] = 0; cyc_rd[d] = 0; turn_cyc[d] = 0;
         for (int i = 0; i < 4; i++) rcnt[d][i] = 0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_log(input int d, input int n, input int budget);
      int b;
      b = 0;
      while (glen[d] < n && b < budget) begin
         tick(1);
         b++;
      end
      chk($sformatf("d%0d grants within budget", d), 128'(glen[d] >= n), 128'(1));
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rrd[d] = '0; rwr[d] = '0; radr[d] = '0; rwd[d] = '0;
         l2rsp[d] = 1'b0; l2rd[d] = '0; rsp_lat[d] = 0; stray[d] = 1'b0; lcnt[d] = 0;
         last_resp[d] = '0; last_rdata[d] = '0;
         for (int i = 0; i < 4; i++) keep[d][i] = 1000;
         model_reset(d);
      end
      clr_stats();
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("reset busy", 128'(bsy[0]), 128'(0));
      chk("reset grant_id", 128'(gid[0]), 128'(0));
      chk("reset timeout_err", 128'(err[0]), 128'(0));

      // Single read from port 0, L2 answers in the third command cycle.
      clr_stats();
      rsp_lat[0] = 3; keep[0][0] = 1;
      radr[0][15:0] = 16'h1000;
      rrd[0][0] = 1'b1;
      tick(10);
      chk("single l2_read cycles", 128'(cyc_rd[0]), 128'(3));
      chk("single resp count", 128'(rcnt[0][0]), 128'(1));
      chk("single rdata", last_rdata[0], {8{16'hD3C3}});
      // Stray l2_resp while idle must not complete anything.
      stray[0] = 1'b1;
      tick(1);
      stray[0] = 1'b0;
      tick(2);
      chk("stray resp ignored", 128'(rcnt[0][0]), 128'(1));

      // All four ports request continuously: rotation from port 0.
      do_reset();
      clr_stats();
      rsp_lat[0] = 1;
      for (int i = 0; i < 4; i++) begin
         keep[0][i] = 1000;
         radr[0][i*16 +: 16] = 16'(16'h0100 * (i + 1));
      end
      rrd[0] = 4'b1111;
      wait_log(0, 5, 60);
      rrd[0] = 4'b0000;
      tick(4);
      chk("rr grant0", 128'(glog[0][0]), 128'(0));
      chk("rr grant1", 128'(glog[0][1]), 128'(1));
      chk("rr grant2", 128'(glog[0][2]), 128'(2));
      chk("rr grant3", 128'(glog[0][3]), 128'(3));
      chk("rr grant4", 128'(glog[0][4]), 128'(0));
      chk("rr resp port0", 128'(rcnt[0][0]), 128'(2));
      chk("rr resp port3", 128'(rcnt[0][3]), 128'(1));
      // Two turnaround cycles (busy, no command) follow each of the 5 completions.
      chk("turnaround cycles", 128'(turn_cyc[0]), 128'(10));

      // Fixed priority: port 1 keeps winning until it drops after 3 completions.
      clr_stats();
      rsp_lat[1] = 2; keep[1][1] = 3; keep[1][3] = 1;
      radr[1][1*16 +: 16] = 16'h1111;
      radr[1][3*16 +: 16] = 16'h3333;
      rrd[1][1] = 1'b1; rrd[1][3] = 1'b1;
      wait_log(1, 4, 100);
      tick(3);
      chk("fp grant0", 128'(glog[1][0]), 128'(1));
      chk("fp grant1", 128'(glog[1][1]), 128'(1));
      chk("fp grant2", 128'(glog[1][2]), 128'(1));
      chk("fp grant3", 128'(glog[1][3]), 128'(3));

      // Read+write from port 2 is a write; reset mid-GRANT kills it without a resp.
      clr_stats();
      rsp_lat[0] = 0;
      radr[0][2*16 +: 16] = 16'h00A0;
      rwd[0][2*128 +: 128] = {4{32'hDEADBEEF}};
      rrd[0][2] = 1'b1; rwr[0][2] = 1'b1;
      tick(3);
      chk("rw l2_write", 128'(l2w[0]), 128'(1));
      chk("rw l2_read", 128'(l2r[0]), 128'(0));
      chk("rw l2_address", 128'(l2a[0]), 128'(16'h00A0));
      chk("rw grant_id", 128'(gid[0]), 128'(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset l2_write", 128'(l2w[0]), 128'(0));
      chk("async reset busy", 128'(bsy[0]), 128'(0));
      rrd[0] = 4'b0000; rwr[0] = 4'b0000;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk("reset aborted resp", 128'(rcnt[0][2]), 128'(0));

      // Timeout: 8 unanswered GRANT cycles raise the sticky flag.
      clr_stats();
      keep[0][1] = 1;
      radr[0][1*16 +: 16] = 16'h2222;
      rrd[0][1] = 1'b1;
      tick(8);
      chk("timeout after 7 grant cycles", 128'(err[0]), 128'(0));
      tick(1);
      chk("timeout after 8 grant cycles", 128'(err[0]), 128'(1));
      rsp_lat[0] = 1;
      tick(6);
      chk("timeout sticky", 128'(err[0]), 128'(1));
      chk("late resp delivered", 128'(rcnt[0][1]), 128'(1));
      chk("idle after late resp", 128'(bsy[0]), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
